// File: rtl/universal_shift_register_param.sv
// Parametrised universal shift register for serial/parallel conversion.
// Supports shift/rotate in both directions, parallel load and clear, serial
// taps at both ends, and a bit counter that pulses Frame_Done_Out once every
// DATA_WIDTH strobed shifts/rotates.
module universal_shift_register_param #(
  parameter  int unsigned DATA_WIDTH = 16,
  localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Shift_Data_Signal_In,
  input  logic [2:0]            Mode_In,
  input  logic                  Serial_Data_LSB_In,
  input  logic                  Serial_Data_MSB_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Serial_Data_MSB_Out,
  output logic                  Serial_Data_LSB_Out,
  output logic [CNT_WIDTH-1:0]  Bit_Count_Out,
  output logic                  Frame_Done_Out
);

  typedef enum logic [2:0] {
    ModeHold     = 3'b000,
    ModeShl      = 3'b001,
    ModeShr      = 3'b010,
    ModeRol      = 3'b011,
    ModeRor      = 3'b100,
    ModeLoad     = 3'b101,
    ModeClear    = 3'b110,
    ModeHoldAlt  = 3'b111
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_frame_done;

  mode_e                 w_mode;
  logic                  w_op_active;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic                  w_is_shift;
  logic                  w_cnt_zero;
  logic [CNT_WIDTH-1:0]  w_cnt_next;
  logic                  w_frame_wrap;

  assign w_mode      = mode_e'(Mode_In);
  // Disabled or unstrobed edges leave data and counter untouched.
  assign w_op_active = Enable_In & Shift_Data_Signal_In;

  // Decode the mode into the next register value and the counter action.
  always_comb begin
    w_data_next = r_data;
    w_is_shift  = 1'b0;
    w_cnt_zero  = 1'b0;
    unique case (w_mode)
      ModeShl: begin
        w_data_next = {r_data[DATA_WIDTH-2:0], Serial_Data_LSB_In};
        w_is_shift  = 1'b1;
      end
      ModeShr: begin
        w_data_next = {Serial_Data_MSB_In, r_data[DATA_WIDTH-1:1]};
        w_is_shift  = 1'b1;
      end
      ModeRol: begin
        w_data_next = {r_data[DATA_WIDTH-2:0], r_data[DATA_WIDTH-1]};
        w_is_shift  = 1'b1;
      end
      ModeRor: begin
        w_data_next = {r_data[0], r_data[DATA_WIDTH-1:1]};
        w_is_shift  = 1'b1;
      end
      ModeLoad: begin
        w_data_next = Parallel_Data_In;
        w_cnt_zero  = 1'b1;
      end
      ModeClear: begin
        w_data_next = '0;
        w_cnt_zero  = 1'b1;
      end
      ModeHold, ModeHoldAlt: begin
        w_data_next = r_data;
      end
      default: begin
        w_data_next = r_data;
      end
    endcase
  end

  // Modulo-DATA_WIDTH counter step; a wrap marks the end of a frame.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_frame_wrap = 1'b0;
    if (w_cnt_zero) begin
      w_cnt_next = '0;
    end else if (w_is_shift) begin
      if (r_cnt == CntLast) begin
        w_cnt_next   = '0;
        w_frame_wrap = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Data register: reset first, otherwise update only on active strobes.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_data <= '0;
    end else if (w_op_active) begin
      r_data <= w_data_next;
    end
  end

  // Bit counter: frozen while disabled or unstrobed.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_cnt <= '0;
    end else if (w_op_active) begin
      r_cnt <= w_cnt_next;
    end
  end

  // Frame pulse: lasts one cycle, cleared at every edge regardless of enable.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_op_active & w_frame_wrap;
    end
  end

  assign Parallel_Data_Out   = r_data;
  assign Bit_Count_Out       = r_cnt;
  assign Frame_Done_Out      = r_frame_done;
  // Serial taps show the bit the next shift will expel; released when disabled.
  assign Serial_Data_MSB_Out = Enable_In ? r_data[DATA_WIDTH-1] : 1'bz;
  assign Serial_Data_LSB_Out = Enable_In ? r_data[0] : 1'bz;

endmodule

// File: tb/tb_universal_shift_register_param.sv
// Bench for universal_shift_register_param: a 16-bit and a 5-bit instance run
// in lockstep on shared stimulus, each against its own reference model.
module tb_universal_shift_register_param;

  logic        clk = 1'b0;
  logic        rst, en, sh, sin_lsb, sin_msb;
  logic [2:0]  mode;
  logic [15:0] pdata;

  logic [15:0] pout16;
  wire         smsb16, slsb16;
  logic [3:0]  cnt16;
  logic        fd16;

  logic [4:0]  pout5;
  wire         smsb5, slsb5;
  logic [2:0]  cnt5;
  logic        fd5;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    int          cnt;
    logic        fd;
    logic        en;
  } exp_t;

  exp_t q16[$];
  exp_t q5[$];

  logic [15:0] m16_data = '0;
  int          m16_cnt  = 0;
  logic [15:0] m5_data  = '0;
  int          m5_cnt   = 0;

  always #5 clk = ~clk;

  universal_shift_register_param #(.DATA_WIDTH(16)) u_dut16 (
    .Clk_In               (clk),
    .Reset_In             (rst),
    .Enable_In            (en),
    .Shift_Data_Signal_In (sh),
    .Mode_In              (mode),
    .Serial_Data_LSB_In   (sin_lsb),
    .Serial_Data_MSB_In   (sin_msb),
    .Parallel_Data_In     (pdata),
    .Parallel_Data_Out    (pout16),
    .Serial_Data_MSB_Out  (smsb16),
    .Serial_Data_LSB_Out  (slsb16),
    .Bit_Count_Out        (cnt16),
    .Frame_Done_Out       (fd16)
  );

  universal_shift_register_param #(.DATA_WIDTH(5)) u_dut5 (
    .Clk_In               (clk),
    .Reset_In             (rst),
    .Enable_In            (en),
    .Shift_Data_Signal_In (sh),
    .Mode_In              (mode),
    .Serial_Data_LSB_In   (sin_lsb),
    .Serial_Data_MSB_In   (sin_msb),
    .Parallel_Data_In     (pdata[4:0]),
    .Parallel_Data_Out    (pout5),
    .Serial_Data_MSB_Out  (smsb5),
    .Serial_Data_LSB_Out  (slsb5),
    .Bit_Count_Out        (cnt5),
    .Frame_Done_Out       (fd5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour for a register of width w held in the low bits.
  task automatic model(input int w, input logic [15:0] d_in, input int c_in,
                       output logic [15:0] d_out, output int c_out, output logic fd_out);
    logic [15:0] mask;
    logic        counts;
    mask   = 16'((32'd1 << w) - 1);
    d_out  = d_in;
    c_out  = c_in;
    fd_out = 1'b0;
    counts = 1'b0;
    if (rst) begin
      d_out = '0;
      c_out = 0;
    end else if (en && sh) begin
      case (mode)
        3'd1: begin d_out = ((d_in << 1) | {15'd0, sin_lsb}) & mask; counts = 1'b1; end
        3'd2: begin d_out = (d_in >> 1) | (16'(sin_msb) << (w - 1)); counts = 1'b1; end
        3'd3: begin d_out = ((d_in << 1) | {15'd0, d_in[w-1]}) & mask; counts = 1'b1; end
        3'd4: begin d_out = (d_in >> 1) | (16'(d_in[0]) << (w - 1)); counts = 1'b1; end
        3'd5: begin d_out = pdata & mask; c_out = 0; end
        3'd6: begin d_out = '0; c_out = 0; end
        default: ;
      endcase
      if (counts) begin
        if (c_in == w - 1) begin
          c_out  = 0;
          fd_out = 1'b1;
        end else begin
          c_out = c_in + 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s, input logic [2:0] m,
                      input logic li, input logic mi, input logic [15:0] pd);
    exp_t x16, x5;
    @(negedge clk);
    rst = r; en = e; sh = s; mode = m; sin_lsb = li; sin_msb = mi; pdata = pd;
    #1;
    model(16, m16_data, m16_cnt, x16.data, x16.cnt, x16.fd);
    model(5, m5_data, m5_cnt, x5.data, x5.cnt, x5.fd);
    x16.en = e;
    x5.en  = e;
    m16_data = x16.data; m16_cnt = x16.cnt;
    m5_data  = x5.data;  m5_cnt  = x5.cnt;
    q16.push_back(x16);
    q5.push_back(x5);
    @(posedge clk);
    #1;
    x16 = q16.pop_front();
    x5  = q5.pop_front();
    check_eq("data16", {16'd0, pout16}, {16'd0, x16.data});
    check_eq("cnt16", {28'd0, cnt16}, x16.cnt);
    check_eq("fd16", {31'd0, fd16}, {31'd0, x16.fd});
    check_eq("data5", {27'd0, pout5}, {16'd0, x5.data});
    check_eq("cnt5", {29'd0, cnt5}, x5.cnt);
    check_eq("fd5", {31'd0, fd5}, {31'd0, x5.fd});
    if (x16.en) begin
      check_eq("smsb16", {31'd0, smsb16}, {31'd0, x16.data[15]});
      check_eq("slsb16", {31'd0, slsb16}, {31'd0, x16.data[0]});
      check_eq("smsb5", {31'd0, smsb5}, {31'd0, x5.data[4]});
      check_eq("slsb5", {31'd0, slsb5}, {31'd0, x5.data[0]});
    end
  endtask

  task automatic shl(input logic b);
    step(1'b0, 1'b1, 1'b1, 3'd1, b, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] word;
    rst = 1'b1; en = 1'b0; sh = 1'b0; mode = 3'd0;
    sin_lsb = 1'b0; sin_msb = 1'b0; pdata = '0;

    // 1: reset, reset after arbitrary state, reset while disabled
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 16'h1234);
    shl(1'b1);
    step(1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 16'hFFFF);
    check_eq("rst_dis_data", {16'd0, pout16}, 32'h0);
    check_eq("rst_dis_cnt", {28'd0, cnt16}, 32'h0);

    // 2: load then 16 rotate-left returns the word with one frame pulse
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 16'hA5C3);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 16'h0);
    check_eq("rol_data", {16'd0, pout16}, 32'hA5C3);
    check_eq("rol_fd", {31'd0, fd16}, 32'h1);
    check_eq("rol_cnt", {28'd0, cnt16}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0);
    check_eq("rol_fd_drop", {31'd0, fd16}, 32'h0);

    // 3: deserialize 0xBEEF MSB first, then a single shift right
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 16'h0);
    word = 16'hBEEF;
    for (int i = 15; i >= 0; i--) shl(word[i]);
    check_eq("deser_data", {16'd0, pout16}, 32'hBEEF);
    check_eq("deser_fd", {31'd0, fd16}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 16'h0001);
    check_eq("lsb_before", {31'd0, slsb16}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 16'h0);
    check_eq("shr_data", {16'd0, pout16}, 32'h8000);

    // 4: freeze mid-frame, then finish the frame
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 16'h0F0F);
    for (int i = 0; i < 6; i++) shl(1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 1'b1, 3'($urandom_range(7)), 1'($urandom), 1'($urandom),
           16'($urandom));
    check_eq("frz_cnt", {28'd0, cnt16}, 32'd6);
    for (int i = 0; i < 9; i++) shl(1'b0);
    check_eq("frz_no_fd", {31'd0, fd16}, 32'h0);
    shl(1'b0);
    check_eq("frz_fd", {31'd0, fd16}, 32'h1);

    // 5: reset mid-frame discards progress
    for (int i = 0; i < 7; i++) shl(1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 9; i++) shl(1'b1);
    check_eq("rstmid_no_fd", {31'd0, fd16}, 32'h0);
    for (int i = 0; i < 7; i++) shl(1'b1);
    check_eq("rstmid_fd", {31'd0, fd16}, 32'h1);

    // 6: strobe gap holds, clear zeroes count without a pulse
    for (int i = 0; i < 5; i++) shl(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 16'h0);
    check_eq("gap_cnt", {28'd0, cnt16}, 32'd5);
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 16'h0);
    check_eq("clr_data", {16'd0, pout16}, 32'h0);
    check_eq("clr_cnt", {28'd0, cnt16}, 32'h0);
    check_eq("clr_fd", {31'd0, fd16}, 32'h0);

    // 5-bit instance: load then 5 rotates wraps at 5
    step(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 16'hA5C3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 16'h0);
    check_eq("w5_data", {27'd0, pout5}, 32'h03);
    check_eq("w5_fd", {31'd0, fd5}, 32'h1);
    check_eq("w5_cnt", {29'd0, cnt5}, 32'h0);

    // Mixed random traffic against both models
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(39) == 0), 1'($urandom_range(7) != 0), 1'($urandom_range(5) != 0),
           3'($urandom_range(7)), 1'($urandom), 1'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
